execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe.sv | 165 ++++++++++++++++
 tb/tb_execute_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// ============================================================================
// Module      : execute_pipe
// Description : Y86-64 style execute stage: ALU, condition codes, branch and
//               conditional-move evaluation, and the E->M pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic [2:0]       E_stat,
    input  logic             cc_kill,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic [2:0]       cc,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic [2:0]       M_stat
);

    localparam logic [3:0]       c_INOP    = 4'h1;
    localparam logic [3:0]       c_IRRMOVQ = 4'h2;
    localparam logic [3:0]       c_IIRMOVQ = 4'h3;
    localparam logic [3:0]       c_IRMMOVQ = 4'h4;
    localparam logic [3:0]       c_IMRMOVQ = 4'h5;
    localparam logic [3:0]       c_IOPQ    = 4'h6;
    localparam logic [3:0]       c_IJXX    = 4'h7;
    localparam logic [3:0]       c_ICALL   = 4'h8;
    localparam logic [3:0]       c_IRET    = 4'h9;
    localparam logic [3:0]       c_IPUSHQ  = 4'hA;
    localparam logic [3:0]       c_IPOPQ   = 4'hB;
    localparam logic [3:0]       c_RNONE   = 4'hF;
    localparam logic [2:0]       c_SAOK    = 3'd1;
    localparam logic [2:0]       c_CC_RST  = 3'b100;
    localparam logic [WIDTH-1:0] c_STEP    = WIDTH'(WIDTH / 8);
    localparam int               c_MSB     = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_valE;
    logic             w_of;
    logic             w_opq_valid;
    logic             w_setcc;
    logic [2:0]       w_flags;
    logic             w_zf;
    logic             w_sf;
    logic             w_ovf;
    logic             w_cond;
    logic             w_cnd;

    assign w_sum  = E_valB + E_valA;
    assign w_diff = E_valB - E_valA;

    always_comb begin
        w_valE      = '0;
        w_of        = 1'b0;
        w_opq_valid = 1'b0;
        case (E_icode)
            c_IOPQ: begin
                case (E_ifun)
                    4'h0: begin
                        w_valE      = w_sum;
                        w_of        = (E_valA[c_MSB] == E_valB[c_MSB]) &&
                                      (w_sum[c_MSB] != E_valA[c_MSB]);
                        w_opq_valid = 1'b1;
                    end
                    4'h1: begin
                        w_valE      = w_diff;
                        w_of        = (E_valB[c_MSB] != E_valA[c_MSB]) &&
                                      (w_diff[c_MSB] != E_valB[c_MSB]);
                        w_opq_valid = 1'b1;
                    end
                    4'h2: begin
                        w_valE      = E_valB & E_valA;
                        w_opq_valid = 1'b1;
                    end
                    4'h3: begin
                        w_valE      = E_valB ^ E_valA;
                        w_opq_valid = 1'b1;
                    end
                    default: w_valE = '0;
                endcase
            end
            c_IRRMOVQ:           w_valE = E_valA;
            c_IIRMOVQ:           w_valE = E_valC;
            c_IRMMOVQ,
            c_IMRMOVQ:           w_valE = E_valB + E_valC;
            c_ICALL, c_IPUSHQ:   w_valE = E_valB - c_STEP;
            c_IRET, c_IPOPQ:     w_valE = E_valB + c_STEP;
            default:             w_valE = '0;
        endcase
    end

    assign w_flags = {(w_valE == '0), w_valE[c_MSB], w_of};
    assign w_setcc = (E_icode == c_IOPQ) && w_opq_valid && !cc_kill;

    // Conditions see the flags from before this instruction's own CC write.
    assign {w_zf, w_sf, w_ovf} = cc;

    always_comb begin
        w_cond = 1'b0;
        case (E_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (w_sf ^ w_ovf) | w_zf;
            4'h2:    w_cond = w_sf ^ w_ovf;
            4'h3:    w_cond = w_zf;
            4'h4:    w_cond = !w_zf;
            4'h5:    w_cond = !(w_sf ^ w_ovf);
            4'h6:    w_cond = !(w_sf ^ w_ovf) && !w_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd  = ((E_icode == c_IRRMOVQ) || (E_icode == c_IJXX)) && w_cond;
    assign e_valE = w_valE;
    assign e_dstE = ((E_icode == c_IRRMOVQ) && !w_cnd) ? c_RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= c_CC_RST;
        end else if (w_setcc) begin
            cc <= w_flags;
        end
    end

    // Bubble wins over stall so a flushed instruction never lingers in M.
    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_icode <= c_INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= c_RNONE;
            M_dstM  <= c_RNONE;
            M_stat  <= c_SAOK;
        end else if (!M_stall) begin
            M_icode <= E_icode;
            M_Cnd   <= w_cnd;
            M_valE  <= w_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
            M_stat  <= E_stat;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_pipe.sv
// ============================================================================
// Module      : tb_execute_pipe
// Description : Self-checking bench for execute_pipe with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0] E_valA, E_valB, E_valC;
    logic [2:0]   E_stat;
    logic         cc_kill, M_stall, M_bubble;

    logic [W-1:0] e_valE, M_valE, M_valA;
    logic [3:0]   e_dstE, M_icode, M_dstE, M_dstM;
    logic [2:0]   cc, M_stat;
    logic         M_Cnd;

    logic [31:0]  valA32, valB32, valC32;
    logic [31:0]  e_valE32, M_valE32, M_valA32;
    logic [3:0]   e_dstE32, M_icode32, M_dstE32, M_dstM32;
    logic [2:0]   cc32, M_stat32;
    logic         M_Cnd32;

    assign valA32 = E_valA[31:0];
    assign valB32 = E_valB[31:0];
    assign valC32 = E_valC[31:0];

    always #5 clk = ~clk;

    execute_pipe #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
        .cc_kill(cc_kill), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .cc(cc),
        .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat)
    );

    execute_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(valA32), .E_valB(valB32), .E_valC(valC32),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat),
        .cc_kill(cc_kill), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE32), .e_dstE(e_dstE32), .cc(cc32),
        .M_icode(M_icode32), .M_Cnd(M_Cnd32), .M_valE(M_valE32), .M_valA(M_valA32),
        .M_dstE(M_dstE32), .M_dstM(M_dstM32), .M_stat(M_stat32)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference state: condition codes and the expected M register contents.
    logic [2:0]   m_cc;
    logic [3:0]   m_icode, m_dstE, m_dstM;
    logic         m_cnd;
    logic [W-1:0] m_valE, m_valA;
    logic [2:0]   m_stat;

    logic [W-1:0] x_valE;
    bit           x_setcc;
    logic [2:0]   x_flags;
    bit           x_cnd;
    logic [3:0]   x_dstE;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Overflow taken as "true signed result does not fit in W bits".
    task automatic ref_exec();
        logic signed [W:0] full;
        bit of, zf, sf, ov, cond;
        x_valE  = '0;
        x_setcc = 0;
        of      = 0;
        case (E_icode)
            4'h6: begin
                x_setcc = (E_ifun <= 4'h3);
                case (E_ifun)
                    4'h0: begin
                        full   = $signed({E_valB[W-1], E_valB}) + $signed({E_valA[W-1], E_valA});
                        x_valE = full[W-1:0];
                        of     = (full[W] != full[W-1]);
                    end
                    4'h1: begin
                        full   = $signed({E_valB[W-1], E_valB}) - $signed({E_valA[W-1], E_valA});
                        x_valE = full[W-1:0];
                        of     = (full[W] != full[W-1]);
                    end
                    4'h2:    x_valE = E_valB & E_valA;
                    4'h3:    x_valE = E_valB ^ E_valA;
                    default: x_valE = '0;
                endcase
            end
            4'h2:       x_valE = E_valA;
            4'h3:       x_valE = E_valC;
            4'h4, 4'h5: x_valE = E_valB + E_valC;
            4'h8, 4'hA: x_valE = E_valB - 8;
            4'h9, 4'hB: x_valE = E_valB + 8;
            default:    x_valE = '0;
        endcase
        x_flags = {x_valE == 0, x_valE[W-1], of};
        zf = m_cc[2];
        sf = m_cc[1];
        ov = m_cc[0];
        case (E_ifun)
            4'h0:    cond = 1;
            4'h1:    cond = (sf != ov) || zf;
            4'h2:    cond = (sf != ov);
            4'h3:    cond = zf;
            4'h4:    cond = !zf;
            4'h5:    cond = (sf == ov);
            4'h6:    cond = (sf == ov) && !zf;
            default: cond = 0;
        endcase
        x_cnd  = (E_icode == 4'h2 || E_icode == 4'h7) ? cond : 0;
        x_dstE = (E_icode == 4'h2 && !x_cnd) ? 4'hF : E_dstE;
    endtask

    task automatic model_bubble();
        m_icode = 4'h1; m_cnd = 0; m_valE = '0; m_valA = '0;
        m_dstE = 4'hF; m_dstM = 4'hF; m_stat = 3'd1;
    endtask

    // One clock: check forwarding outputs, take the edge, check registered state.
    task automatic cycle();
        #1;
        ref_exec();
        chk("e_valE", e_valE, x_valE);
        chk("e_dstE", W'(e_dstE), W'(x_dstE));
        @(posedge clk);
        #1;
        if (rst) begin
            m_cc = 3'b100;
            model_bubble();
        end else begin
            if (x_setcc && !cc_kill) m_cc = x_flags;
            if (M_bubble) model_bubble();
            else if (!M_stall) begin
                m_icode = E_icode; m_cnd = x_cnd; m_valE = x_valE; m_valA = E_valA;
                m_dstE = x_dstE; m_dstM = E_dstM; m_stat = E_stat;
            end
        end
        chk("cc", W'(cc), W'(m_cc));
        chk("M_icode", W'(M_icode), W'(m_icode));
        chk("M_Cnd", W'(M_Cnd), W'(m_cnd));
        chk("M_valE", M_valE, m_valE);
        chk("M_valA", M_valA, m_valA);
        chk("M_dstE", W'(M_dstE), W'(m_dstE));
        chk("M_dstM", W'(M_dstM), W'(m_dstM));
        chk("M_stat", W'(M_stat), W'(m_stat));
    endtask

    task automatic setop(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] de);
        E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
        E_dstE = de; E_dstM = 4'hF; E_stat = 3'd1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = W'($urandom_range(0, 15));
            2:       v = $urandom_range(0, 1) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            default: v = {W{1'b1}} - W'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};

    initial begin
        rst = 1; cc_kill = 0; M_stall = 0; M_bubble = 0;
        setop(4'h0, 4'h0, '0, '0, '0, 4'hF);
        m_cc = 3'b100;
        model_bubble();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_cc", W'(cc), W'(3'b100));
        chk("rst_M_icode", W'(M_icode), W'(4'h1));
        chk("rst_M_dstE", W'(M_dstE), W'(4'hF));
        chk("rst_M_stat", W'(M_stat), W'(3'd1));
        rst = 0;

        // Add, then the first post-reset edge loads normally
        setop(4'h6, 4'h0, 25, 20, 0, 4'h2);
        cycle();
        chk("add_valE", e_valE, 45);
        chk("add_cc", W'(cc), W'(3'b000));
        chk("add_M_valE", M_valE, 45);
        chk("add_M_icode", W'(M_icode), W'(4'h6));

        // Signed overflow boundaries
        setop(4'h6, 4'h1, 1, c_MIN, 0, 4'h2);
        cycle();
        chk("subovf_valE", M_valE, c_MAX);
        chk("subovf_cc", W'(cc), W'(3'b001));
        setop(4'h6, 4'h0, 1, c_MAX, 0, 4'h2);
        cycle();
        chk("addovf_cc", W'(cc), W'(3'b011));

        // Conditional moves and jumps against cc from 20-15
        setop(4'h6, 4'h1, 15, 20, 0, 4'h2);
        cycle();
        chk("sub_cc", W'(cc), W'(3'b000));
        setop(4'h2, 4'h6, 99, 0, 0, 4'h3);
        cycle();
        chk("cmovg_Cnd", W'(M_Cnd), 1);
        chk("cmovg_dstE", W'(M_dstE), 3);
        setop(4'h7, 4'h1, 0, 0, 64'h40, 4'hF);
        cycle();
        chk("jle_Cnd", W'(M_Cnd), 0);
        setop(4'h2, 4'h1, 99, 0, 0, 4'h3);
        cycle();
        chk("cmovle_dstE", W'(M_dstE), W'(4'hF));

        // cc_kill blocks the flag write
        setop(4'h6, 4'h1, 1, 0, 0, 4'h2);
        cycle();
        chk("neg_cc", W'(cc), W'(3'b010));
        setop(4'h6, 4'h3, 7, 7, 0, 4'h2);
        cc_kill = 1;
        cycle();
        chk("kill_valE", e_valE, 0);
        chk("kill_cc", W'(cc), W'(3'b010));
        cc_kill = 0;
        cycle();
        chk("xor_cc", W'(cc), W'(3'b100));

        // Stack pointer step scales with WIDTH
        setop(4'hA, 4'h0, 0, 64'h100, 0, 4'h4);
        cycle();
        chk("push_M_valE", M_valE, 64'hF8);
        chk("push32_M_valE", W'(M_valE32), 64'hFC);
        setop(4'hB, 4'h0, 0, 64'h100, 0, 4'h4);
        cycle();
        chk("pop_M_valE", M_valE, 64'h108);
        chk("pop32_M_valE", W'(M_valE32), 64'h104);

        // Stall holds M but not cc; bubble beats stall; reset beats all
        setop(4'h6, 4'h0, 3, 4, 0, 4'h2);
        cycle();
        setop(4'h6, 4'h1, 100, 100, 0, 4'h5);
        M_stall = 1;
        cycle();
        cycle();
        chk("stall_M_valE", M_valE, 7);
        chk("stall_cc", W'(cc), W'(3'b100));
        M_bubble = 1;
        cycle();
        chk("bubble_M_icode", W'(M_icode), W'(4'h1));
        chk("bubble_M_valE", M_valE, 0);
        M_bubble = 0;
        M_stall = 1;
        setop(4'h6, 4'h1, 1, 0, 0, 4'h2);
        rst = 1;
        cycle();
        chk("midrst_cc", W'(cc), W'(3'b100));
        chk("midrst_M_icode", W'(M_icode), W'(4'h1));
        chk("midrst_M_stat", W'(M_stat), W'(3'd1));
        rst = 0;
        M_stall = 0;
        setop(4'h6, 4'h0, 1, 2, 0, 4'h2);
        cycle();
        chk("postrst_M_icode", W'(M_icode), W'(4'h6));

        for (int i = 0; i < 400; i++) begin
            E_icode  = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 11));
            E_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 6));
            E_valA   = rnd_val();
            E_valB   = rnd_val();
            E_valC   = rnd_val();
            E_dstE   = 4'($urandom_range(0, 15));
            E_dstM   = 4'($urandom_range(0, 15));
            E_stat   = 3'($urandom_range(1, 4));
            cc_kill  = ($urandom_range(0, 3) == 0);
            M_stall  = ($urandom_range(0, 7) == 0);
            M_bubble = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
